// File: rtl/pipe_mem_arb_if.sv
// Pipeline-side fetch/data request lines plus the shared req/ack memory bus.
// master = arbiter view, slave = pipeline and memory view.
interface pipe_mem_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] if_inst;
  logic        if_ready;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        pipe_stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_inst, if_ready, d_rdata, d_ready, pipe_stall, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_inst, if_ready, d_rdata, d_ready, pipe_stall, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pipe_mem_arb.sv
// Shares one req/ack memory between fetch and data access (data first); results are buffered
// and pipe_stall holds the pipeline until both complete. A watchdog aborts unacked requests.
module pipe_mem_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clock,
  input  logic           resetn,
  pipe_mem_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] inst_buf;
  logic [31:0] rdata_buf;
  logic        if_done;
  logic        d_done;
  logic [7:0]  wd_cnt;
  logic        bus_err;

  logic        dpend;
  logic        start_d;
  logic        start_f;
  logic        busy;
  logic        timeout;
  logic        acc_end;
  logic [31:0] rd_val;
  logic        pipe_stall;

  assign dpend   = bus.d_rd | bus.d_wr;
  assign start_d = dpend & ~d_done;
  assign start_f = bus.if_req & ~if_done;
  assign busy    = (state == DATA) || (state == FETCH);
  assign timeout = busy && !bus.mem_ack && (wd_cnt == WD_LAST);
  assign acc_end = busy && (bus.mem_ack || timeout);
  // An aborted access completes with zero read data.
  assign rd_val  = bus.mem_ack ? bus.mem_rdata : 32'h0;

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_d)      state_nxt = DATA;
        else if (start_f) state_nxt = FETCH;
      end
      DATA, FETCH: begin
        if (acc_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pipe_stall     = (bus.if_req & ~if_done) | (dpend & ~d_done);
    bus.pipe_stall = pipe_stall;
    bus.if_ready   = if_done;
    bus.d_ready    = d_done;
    bus.if_inst    = inst_buf;
    bus.d_rdata    = rdata_buf;
    bus.bus_err    = bus_err;
    bus.mem_req    = mem_req;
    bus.mem_we     = mem_we;
    bus.mem_addr   = mem_addr;
    bus.mem_wdata  = mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      inst_buf  <= 32'h0;
      rdata_buf <= 32'h0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      wd_cnt    <= 8'h0;
      bus_err   <= 1'b0;
    end else begin
      if (!pipe_stall) begin
        if_done <= 1'b0;
        d_done  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_d) begin
            mem_req   <= 1'b1;
            mem_we    <= bus.d_wr;
            mem_addr  <= bus.d_addr;
            mem_wdata <= bus.d_wdata;
            wd_cnt    <= 8'h0;
          end else if (start_f) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= bus.if_addr;
            wd_cnt   <= 8'h0;
          end
        end
        DATA, FETCH: begin
          if (acc_end) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (timeout) bus_err <= 1'b1;
            if (state == DATA) begin
              d_done <= 1'b1;
              if (!mem_we) rdata_buf <= rd_val;
            end else begin
              if_done  <= 1'b1;
              inst_buf <= rd_val;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pipe_mem_arb.md
# pipe_mem_arb

Arbiter and sequencer that shares one single-port, variable-latency memory between the pipeline's instruction fetch (IF) and data access (MEM) stages. It serialises fetch and load/store requests onto a req/ack memory bus and buffers completed results. It also generates the global `pipe_stall` that freezes the PC and every pipeline register until both the current fetch and the current data access have completed. A watchdog aborts accesses that never get `mem_ack` and flags a sticky bus error.

## Interface
- `TIMEOUT`, 16: max cycles `mem_req` stays high without `mem_ack` before abort (2..255)
- `clock` in 1: single clock, all state updates on rising edge
- `resetn` in 1: synchronous, active-low reset
- `if_req` in 1: IF stage wants an instruction
- `if_addr` in 32: fetch address (PC)
- `d_rd` in 1: MEM stage load (mm2reg)
- `d_wr` in 1: MEM stage store (mwmem); never high together with `d_rd`
- `d_addr` in 32: data address (malu)
- `d_wdata` in 32: store data
- `if_inst` out 32: fetched instruction, valid while `if_ready`
- `if_ready` out 1: fetch for current cycle complete
- `d_rdata` out 32: load data, valid while `d_ready`
- `d_ready` out 1: data access for current cycle complete
- `pipe_stall` out 1: freeze PC and all pipeline registers
- `bus_err` out 1: sticky, set on any timeout
- `mem_req` out 1: memory request
- `mem_we` out 1: write strobe, qualified by `mem_req`
- `mem_addr` out 32: memory address
- `mem_wdata` out 32: memory write data
- `mem_rdata` in 32: memory read data, valid with `mem_ack`
- `mem_ack` in 1: one-cycle completion pulse from memory

## Operation
- `dpend = d_rd | d_wr`
- Flags `if_done` and `d_done` record completion. Buffers `inst_buf` and `rdata_buf` hold the results.
- Combinational outputs:
  - `if_ready = if_done`
  - `d_ready = d_done`
  - `if_inst = inst_buf`
  - `d_rdata = rdata_buf`
  - `pipe_stall = (if_req & ~if_done) | (dpend & ~d_done)`
- Advance: at any edge with `pipe_stall == 0`, clear `if_done` and `d_done`. Both requests are re-evaluated fresh on the next cycle.
- FSM states are IDLE, DATA and FETCH.
- **IDLE:**
  - If `dpend & ~d_done`: go to DATA. Register `mem_addr = d_addr`, `mem_we = d_wr`, `mem_wdata = d_wdata`, `mem_req = 1`.
  - Else if `if_req & ~if_done`: go to FETCH. Register `mem_addr = if_addr`, `mem_we = 0`, `mem_req = 1`.
  - Data has priority over fetch because it belongs to the older instruction.
- **DATA / FETCH:**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable.
  - On an edge with `mem_ack = 1`:
    - `mem_req = 0`, `mem_we = 0`, go to IDLE.
    - In DATA: `d_done = 1`, and for a load `rdata_buf = mem_rdata`. A store leaves `rdata_buf` unchanged.
    - In FETCH: `if_done = 1`, `inst_buf = mem_rdata`.
- **Watchdog:**
  - An 8-bit counter clears on entry to DATA or FETCH and increments each cycle without an ack.
  - When the count reaches `TIMEOUT - 1` with no ack, complete as if acked with read data 0, and set `bus_err = 1`.
  - `bus_err` clears only on reset.
- A `mem_ack` arriving in IDLE is ignored.
- Requester inputs are only sampled on the IDLE→DATA/FETCH transition. While stalled, the pipeline holds them stable.

## Timing
- Reset (edge with `resetn = 0`):
  - state IDLE
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `inst_buf`, `rdata_buf`, `if_done`, `d_done`, watchdog and `bus_err` all cleared to 0
  - so `if_ready = d_ready = 0`, and `pipe_stall = if_req | dpend`
- Reset mid-access drops `mem_req` at that edge and discards any pending result.
- Fetch only, memory acks at the L-th cycle of `mem_req` (L ≥ 1):
  - request seen in cycle 0, `mem_req` high in cycles 1..L
  - `if_ready` high from cycle L+1
  - pipeline advances at the end of cycle L+1
- Load and fetch together:
  - data access first, then one IDLE cycle, then fetch
  - `pipe_stall` stays high until both flags are set
- `mem_req` never rises in the cycle after an ack (one-cycle IDLE turnaround).
- Timeout completion occurs at the end of cycle `TIMEOUT` of `mem_req`.

## Test plan
- Reset, `if_req=1`, `if_addr=0x100`, memory acks with L=2 and rdata `0x8C010004` → `mem_req` high cycles 1–2 with `mem_addr=0x100`, `mem_we=0`; `if_ready=1` and `if_inst=0x8C010004` in cycle 3; `pipe_stall` 1 in cycles 0–2, 0 in cycle 3.
- `d_rd=1`, `d_addr=0x40`, `if_req=1`, `if_addr=0x104`, L=1 → data access first (`mem_addr=0x40`), `d_rdata` = memory word; fetch `mem_req` rises two cycles after the data ack; `pipe_stall` drops only after the fetch completes.
- `d_wr=1`, `d_addr=0x80`, `d_wdata=0xDEADBEEF` → `mem_we=1`, `mem_wdata=0xDEADBEEF` for the whole request; `rdata_buf` unchanged; `d_ready=1` after the ack.
- No ack, `TIMEOUT=16` → `mem_req` drops after 16 cycles; completes with `d_rdata=0` (or `if_inst=0` for a fetch); `bus_err=1` and stays 1 through further accesses.
- `resetn` pulled low in the 2nd cycle of a fetch with L=4 → `mem_req=0` at that edge; late ack ignored; `if_ready=0`; fresh fetch starts after release.
- Back-to-back fetches at 0x0, 0x4 and 0x8 with L=1 → one instruction per 3 cycles; `if_done` cleared on each advance edge.
